// File: rtl/axis_fifo_wr_arbiter.sv
// Round-robin packet arbiter merging N AXI-Stream requesters into one FIFO write port.
// A grant is held for a whole packet; each packet pays one IDLE cycle for arbitration.

module axis_fifo_wr_arbiter_lane #(
  parameter int DW = 8,
  parameter int IW = 2,
  parameter int FW = DW + IW + 1,
  parameter int ID = 0
) (
  input  logic          sel,
  input  logic          fifo_full,
  input  logic          tvalid,
  input  logic          tlast,
  input  logic [DW-1:0] tdata,
  output logic          tready,
  output logic          wen,
  output logic [FW-1:0] word
);
  // Unselected lanes contribute zero so the top can OR-reduce the words.
  always_comb begin
    tready = sel & ~fifo_full;
    wen    = tready & tvalid;
    word   = sel ? FW'({tlast, IW'(ID), tdata}) : '0;
  end
endmodule

module axis_fifo_wr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int IW = $clog2(N),
  parameter int FW = DW + IW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N-1:0]    s_tvalid,
  output logic [N-1:0]    s_tready,
  input  logic [N*DW-1:0] s_tdata,
  input  logic [N-1:0]    s_tlast,
  input  logic            fifo_full,
  output logic            fifo_wen,
  output logic [FW-1:0]   fifo_wdata,
  output logic            busy,
  output logic [IW-1:0]   grant_id,
  output logic [15:0]     pkt_cnt
);
  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [N-1:0]        lane_sel, lane_wen;
  logic [N-1:0][FW-1:0] lane_word;
  logic                win_found;
  logic [IW-1:0]       win_id;
  logic                last_xfer;

  always_comb begin
    for (int i = 0; i < N; i++)
      lane_sel[i] = (state_q == LOCK) && (grant_q == IW'(i));
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    axis_fifo_wr_arbiter_lane #(.DW(DW), .IW(IW), .FW(FW), .ID(i)) u_lane (
      .sel       (lane_sel[i]),
      .fifo_full (fifo_full),
      .tvalid    (s_tvalid[i]),
      .tlast     (s_tlast[i]),
      .tdata     (s_tdata[i*DW +: DW]),
      .tready    (s_tready[i]),
      .wen       (lane_wen[i]),
      .word      (lane_word[i])
    );
  end

  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < N; i++) fifo_wdata |= lane_word[i];
  end

  assign fifo_wen  = |lane_wen;
  assign last_xfer = fifo_wen & fifo_wdata[FW-1];

  // First valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!win_found && s_tvalid[idx]) begin
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      IDLE: begin
        if (en && win_found) begin
          state_d = LOCK;
          grant_d = win_id;
        end
      end
      LOCK: begin
        // en is deliberately ignored here: a started packet always finishes.
        if (last_xfer) begin
          state_d   = IDLE;
          rr_ptr_d  = (grant_q == IW'(N-1)) ? '0 : grant_q + IW'(1);
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign busy     = (state_q == LOCK);
  assign grant_id = grant_q;
  assign pkt_cnt  = pkt_cnt_q;
endmodule
